// File: rtl/snes_pad_reader.sv
// snes_pad_reader: periodically polls an SNES controller and presents its 16 buttons active-high.
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   enable        in   permits new polls (a running frame always completes)
//   pad_strb      out  latch pulse to the pad
//   pad_clk       out  pad shift clock, idles high, pad shifts on its falling edge
//   pad_di        in   serial pad data, active-low, asynchronous
//   buttons       out  [15:0] active-high buttons, bit0 = B (first bit shifted)
//   buttons_valid out  one-cycle pulse when buttons updates
//   pad_present   out  pad detected on the last completed frame
// Optional build macro SNES_PAD_PRESENCE_EN: reads a 17th bit to detect an attached pad.
module snes_pad_reader #(
   parameter int CLK_DIV     = 128,
   parameter int POLL_CYCLES = 357954
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   output logic        pad_strb,
   output logic        pad_clk,
   input  logic        pad_di,
   output logic [15:0] buttons,
   output logic        buttons_valid,
   output logic        pad_present
);
`ifdef SNES_PAD_PRESENCE_EN
   localparam int NBITS = 17;
`else
   localparam int NBITS = 16;
`endif
   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [CW-1:0] H_LAST    = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] L_LAST    = CW'(2 * CLK_DIV - 1);
   localparam logic [4:0]    BIT_LAST  = 5'(NBITS - 1);

   typedef enum logic [2:0] {IDLE, LATCH, GAP, LOW, HIGH, DONE} state_t;

   state_t        r_state, w_next;
   logic          r_sync1, r_sync2;
   logic [PW-1:0] r_poll;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_bit;
   logic [15:0]   r_shift, w_shift_next;
   logic          w_wrap, w_last, w_sample, w_done, w_present;

`ifdef SNES_PAD_PRESENCE_EN
   // the 17th sample is taken on the cycle that enters DONE; an attached pad drives it low
   assign w_present = ~r_sync2;
`else
   assign w_present = 1'b1;
`endif

   always_comb begin
      w_wrap   = r_poll == POLL_LAST;
      w_last   = r_cnt == ((r_state == LATCH) ? L_LAST : H_LAST);
      w_sample = w_last && (r_state == GAP || r_state == HIGH);
      w_next   = r_state;
      case (r_state)
         IDLE:    if (w_wrap && enable) w_next = LATCH;
         LATCH:   if (w_last) w_next = GAP;
         GAP:     if (w_last) w_next = LOW;
         LOW:     if (w_last) w_next = HIGH;
         HIGH:    if (w_last) w_next = (r_bit == BIT_LAST) ? DONE : LOW;
         default: w_next = IDLE;
      endcase
      w_done = w_next == DONE;
      // the final stored bit lands on the same edge buttons loads, so buttons takes the merged value
      w_shift_next = r_shift;
      if (w_sample && r_bit < 5'd16) w_shift_next[r_bit[3:0]] = ~r_sync2;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // outputs are decoded from the next state so they are registered yet aligned with the state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_poll        <= '0;
         r_cnt         <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         pad_strb      <= 1'b0;
         pad_clk       <= 1'b1;
         buttons       <= '0;
         buttons_valid <= 1'b0;
         pad_present   <= 1'b0;
      end else begin
         r_sync1       <= pad_di;
         r_sync2       <= r_sync1;
         r_poll        <= w_wrap ? '0 : r_poll + 1'b1;
         r_cnt         <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
         r_bit         <= (r_state == LATCH) ? '0 : r_bit + 5'(w_sample);
         r_shift       <= w_shift_next;
         pad_strb      <= w_next == LATCH;
         pad_clk       <= w_next != LOW;
         buttons_valid <= w_done;
         if (w_done) begin
            buttons     <= w_present ? w_shift_next : 16'h0000;
            pad_present <= w_present;
         end
      end
   end
endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: scoreboard bench for snes_pad_reader with a behavioural SNES pad model.
module tb_snes_pad_reader;
`ifdef SNES_PAD_PRESENCE_EN
   localparam int NB = 17;
   localparam logic PRES_TIED = 1'b0;
`else
   localparam int NB = 16;
   localparam logic PRES_TIED = 1'b1;
`endif
   localparam int H   = 4;
   localparam int LAT = 3 * H + (NB - 1) * 2 * H;

   logic        clk = 1'b0;
   logic        resetn, enable, pad_strb, pad_clk, pad_di, buttons_valid, pad_present;
   logic [15:0] buttons;

   logic [15:0] pat = 16'h0000;
   logic        tie_high = 1'b0;
   int          pidx = 0;

   logic [16:0] q[$];
   int checks = 0, failures = 0;
   int cyc = 0, strb_start = -1, strb_len = 0, low_len = 0, pulses = 0, nvalid = 0, last_valid = 0;
   logic prev_strb = 1'b0, prev_clk = 1'b1, prev_valid = 1'b0;
   logic [15:0] prev_btn = 16'h0000;

   snes_pad_reader #(.CLK_DIV(H), .POLL_CYCLES(200)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .pad_strb(pad_strb), .pad_clk(pad_clk),
      .pad_di(pad_di), .buttons(buttons), .buttons_valid(buttons_valid), .pad_present(pad_present)
   );

   always #5 clk = ~clk;

   always @(negedge pad_clk or posedge pad_strb)
      if (pad_strb) pidx <= 0;
      else          pidx <= pidx + 1;

   assign pad_di = tie_high ? 1'b1 : (pidx < 16 ? ~pat[pidx[3:0]] : (pidx == 16 ? 1'b0 : 1'b1));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int lim);
      int n0 = nvalid;
      for (int i = 0; i < lim && nvalid == n0; i++) @(negedge clk);
      check("valid_seen", int'(nvalid != n0), 1);
   endtask

   task automatic wait_strb(input int lim);
      for (int i = 0; i < lim && !pad_strb; i++) @(negedge clk);
      check("strb_seen", int'(pad_strb), 1);
   endtask

   always @(negedge clk) begin
      logic [16:0] e;
      cyc++;
      if (!resetn) begin
         strb_start = -1;
         strb_len = 0;
         low_len = 0;
         pulses = 0;
      end else begin
         if (pad_strb) begin
            if (!prev_strb) begin
               strb_start = cyc;
               strb_len = 0;
               pulses = 0;
            end
            strb_len++;
         end else if (prev_strb) check("strb_len", strb_len, 2 * H);
         if (!pad_clk) low_len++;
         else if (!prev_clk) begin
            check("low_len", low_len, H);
            pulses++;
            low_len = 0;
         end
         if (!buttons_valid) check("hold", buttons, prev_btn);
         else begin
            nvalid++;
            last_valid = cyc;
            check("valid_width", prev_valid, 0);
            check("valid_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("buttons", buttons, e[15:0]);
               check("present", pad_present, e[16]);
               check("latency", cyc - strb_start, LAT);
               check("clk_pulses", pulses, NB - 1);
            end
         end
      end
      prev_strb  = pad_strb;
      prev_clk   = pad_clk;
      prev_valid = buttons_valid;
      prev_btn   = buttons;
   end

   initial begin
      int t0, n;
      resetn = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_strb", pad_strb, 0);
      check("rst_pclk", pad_clk, 1);
      check("rst_btn", buttons, 0);
      check("rst_valid", buttons_valid, 0);
      check("rst_present", pad_present, 0);
      resetn = 1'b1;
      pat = 16'h0001;
      enable = 1'b1;
      q.push_back({1'b1, 16'h0001});
      wait_valid(400);
      pat = 16'hA5C3;
      q.push_back({1'b1, 16'hA5C3});
      q.push_back({1'b1, 16'hA5C3});
      wait_valid(300);
      t0 = last_valid;
      wait_valid(300);
      check("period", last_valid - t0, 200);
      // drop enable during the LOW phase before bit 5 (frame cycles 44..47)
      pat = 16'h1234;
      q.push_back({1'b1, 16'h1234});
      wait_strb(300);
      repeat (46) @(negedge clk);
      enable = 1'b0;
      wait_valid(200);
      n = 0;
      for (int i = 0; i < 450; i++) begin
         @(negedge clk);
         if (pad_strb) n++;
      end
      check("no_strb", n, 0);
      enable = 1'b1;
      // reset during the HIGH phase of bit 9 (frame cycles 80..83)
      pat = 16'hBEEF;
      wait_strb(300);
      repeat (82) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rstm_strb", pad_strb, 0);
      check("rstm_pclk", pad_clk, 1);
      check("rstm_btn", buttons, 0);
      check("rstm_valid", buttons_valid, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      q.push_back({1'b1, 16'hBEEF});
      wait_valid(500);
      tie_high = 1'b1;
      q.push_back({PRES_TIED, 16'h0000});
      wait_valid(300);
      tie_high = 1'b0;
      pat = 16'h8001;
      q.push_back({1'b1, 16'h8001});
      wait_valid(300);
      enable = 1'b0;
      repeat (20) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
